// File: rtl/bp_fpga_host_nbf_uart_bridge.sv
// Device-side NBF-over-UART bridge: assembles RX bytes into NBF packets and
// serializes response packets into TX bytes, both LSB byte first.
module bp_fpga_host_nbf_uart_bridge #(
  parameter int nbf_width_p      = 112,
  parameter int timeout_cycles_p = 4096,
  parameter int cnt_width_p      = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_v_i,
  input  logic [7:0]             rx_i,
  input  logic                   rx_error_i,
  output logic                   nbf_v_o,
  output logic [nbf_width_p-1:0] nbf_o,
  input  logic                   nbf_ready_and_i,
  input  logic                   nbf_v_i,
  input  logic [nbf_width_p-1:0] nbf_i,
  output logic                   nbf_ready_and_o,
  output logic                   tx_v_o,
  output logic [7:0]             tx_o,
  input  logic                   tx_ready_and_i,
  output logic [cnt_width_p-1:0] drop_count_o,
  output logic [cnt_width_p-1:0] error_count_o
);
  localparam int N  = nbf_width_p / 8;
  localparam int IW = $clog2(N + 1);
  localparam int TW = $clog2(timeout_cycles_p + 1);

  typedef enum logic {RX_FILL, RX_HOLD} rx_state_e;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;

  // RX state; r_pkt doubles as the nbf_o register and is filled in place
  rx_state_e              r_rx_state, w_rx_state_n;
  logic [IW-1:0]          r_rx_idx, w_rx_idx_n;
  logic [nbf_width_p-1:0] r_pkt, w_pkt_n;
  logic                   r_nbf_v, w_nbf_v_n;
  logic [TW-1:0]          r_timer, w_timer_n;
  logic [cnt_width_p-1:0] r_drop, r_err;
  logic                   w_drop_inc, w_err_inc, w_hs;

  always_comb begin
    w_rx_state_n = r_rx_state;
    w_rx_idx_n   = r_rx_idx;
    w_pkt_n      = r_pkt;
    w_nbf_v_n    = r_nbf_v;
    w_timer_n    = r_timer;
    w_drop_inc   = 1'b0;
    w_err_inc    = 1'b0;
    w_hs         = r_nbf_v & nbf_ready_and_i;
    unique case (r_rx_state)
      RX_FILL: begin
        if (rx_error_i) begin
          w_err_inc  = 1'b1;
          w_rx_idx_n = '0;
          w_timer_n  = '0;
        end else if (rx_v_i) begin
          w_pkt_n[8*r_rx_idx +: 8] = rx_i;
          w_timer_n = '0;
          if (r_rx_idx == IW'(N-1)) begin
            w_rx_idx_n   = '0;
            w_rx_state_n = RX_HOLD;
            w_nbf_v_n    = 1'b1;
          end else begin
            w_rx_idx_n = r_rx_idx + 1'b1;
          end
        end else if (r_rx_idx != '0) begin
          // a byte in the expiry cycle is taken above, so timeout never races it
          if (r_timer == TW'(timeout_cycles_p-1)) begin
            w_rx_idx_n = '0;
            w_timer_n  = '0;
            w_drop_inc = 1'b1;
          end else begin
            w_timer_n = r_timer + 1'b1;
          end
        end
      end
      RX_HOLD: begin
        if (rx_error_i) w_err_inc = 1'b1;
        if (w_hs) begin
          w_rx_state_n = RX_FILL;
          w_nbf_v_n    = 1'b0;
          if (rx_v_i && !rx_error_i) begin
            w_pkt_n[7:0] = rx_i;
            w_rx_idx_n   = IW'(1);
            w_timer_n    = '0;
          end
        end else if (rx_v_i && !rx_error_i) begin
          w_drop_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_state <= RX_FILL;
      r_rx_idx   <= '0;
      r_pkt      <= '0;
      r_nbf_v    <= 1'b0;
      r_timer    <= '0;
      r_drop     <= '0;
      r_err      <= '0;
    end else begin
      r_rx_state <= w_rx_state_n;
      r_rx_idx   <= w_rx_idx_n;
      r_pkt      <= w_pkt_n;
      r_nbf_v    <= w_nbf_v_n;
      r_timer    <= w_timer_n;
      if (w_drop_inc && (r_drop != '1)) r_drop <= r_drop + 1'b1;
      if (w_err_inc && (r_err != '1))   r_err  <= r_err + 1'b1;
    end
  end

  // TX path
  tx_state_e              r_tx_state, w_tx_state_n;
  logic [IW-1:0]          r_tx_idx, w_tx_idx_n;
  logic [nbf_width_p-1:0] r_tx_buf, w_tx_buf_n;
  logic                   r_tx_v, w_tx_v_n;
  logic [7:0]             r_tx, w_tx_n;
  logic                   r_rdy, w_rdy_n;

  always_comb begin
    w_tx_state_n = r_tx_state;
    w_tx_idx_n   = r_tx_idx;
    w_tx_buf_n   = r_tx_buf;
    w_tx_v_n     = r_tx_v;
    w_tx_n       = r_tx;
    w_rdy_n      = r_rdy;
    unique case (r_tx_state)
      TX_IDLE: begin
        if (nbf_v_i && r_rdy) begin
          w_tx_buf_n   = nbf_i;
          w_tx_idx_n   = '0;
          w_tx_state_n = TX_SEND;
          w_tx_v_n     = 1'b1;
          w_tx_n       = nbf_i[7:0];
          w_rdy_n      = 1'b0;
        end
      end
      TX_SEND: begin
        if (tx_ready_and_i) begin
          if (r_tx_idx == IW'(N-1)) begin
            w_tx_state_n = TX_IDLE;
            w_tx_v_n     = 1'b0;
            w_tx_n       = '0;
            w_rdy_n      = 1'b1;
          end else begin
            w_tx_idx_n = r_tx_idx + 1'b1;
            w_tx_n     = r_tx_buf[8*w_tx_idx_n +: 8];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_idx   <= '0;
      r_tx_buf   <= '0;
      r_tx_v     <= 1'b0;
      r_tx       <= '0;
      r_rdy      <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_n;
      r_tx_idx   <= w_tx_idx_n;
      r_tx_buf   <= w_tx_buf_n;
      r_tx_v     <= w_tx_v_n;
      r_tx       <= w_tx_n;
      r_rdy      <= w_rdy_n;
    end
  end

  assign nbf_v_o         = r_nbf_v;
  assign nbf_o           = r_pkt;
  assign nbf_ready_and_o = r_rdy;
  assign tx_v_o          = r_tx_v;
  assign tx_o            = r_tx;
  assign drop_count_o    = r_drop;
  assign error_count_o   = r_err;
endmodule

// File: tb/tb_bp_fpga_host_nbf_uart_bridge.sv
// Bench for the NBF UART bridge: directed scenarios plus random traffic,
// every cycle compared against a queue-based packet model.
module tb_bp_fpga_host_nbf_uart_bridge;
  localparam int W = 112;
  localparam int N = W / 8;
  localparam int T = 4096;
  localparam int CMAX = 255;

  logic clk = 1'b0, reset = 1'b1;
  logic rx_v = 1'b0, rx_err = 1'b0, rdy_in = 1'b0, nbf_v_in = 1'b0, tx_rdy = 1'b0;
  logic [7:0] rx_b = '0;
  logic [W-1:0] nbf_in = '0;
  logic nbf_v_o, nbf_ready_and_o, tx_v_o;
  logic [W-1:0] nbf_o;
  logic [7:0] tx_o, drop_count_o, error_count_o;

  always #5 clk = ~clk;

  bp_fpga_host_nbf_uart_bridge #(.nbf_width_p(W), .timeout_cycles_p(T), .cnt_width_p(8)) dut (
    .clk(clk), .reset(reset), .rx_v_i(rx_v), .rx_i(rx_b), .rx_error_i(rx_err),
    .nbf_v_o(nbf_v_o), .nbf_o(nbf_o), .nbf_ready_and_i(rdy_in),
    .nbf_v_i(nbf_v_in), .nbf_i(nbf_in), .nbf_ready_and_o(nbf_ready_and_o),
    .tx_v_o(tx_v_o), .tx_o(tx_o), .tx_ready_and_i(tx_rdy),
    .drop_count_o(drop_count_o), .error_count_o(error_count_o));

  int n_cmp = 0, n_bad = 0, tx_hs = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: partial packet as a byte queue, held packet, pending TX bytes
  logic [7:0]   m_rxq[$];
  logic [7:0]   m_txq[$];
  bit           m_held;
  logic [W-1:0] m_pkt;
  int           m_idle, m_drop, m_err;

  function automatic int sat(input int v);
    return (v + 1 > CMAX) ? CMAX : v + 1;
  endfunction

  task automatic model_reset();
    m_rxq.delete(); m_txq.delete();
    m_held = 0; m_pkt = '0; m_idle = 0; m_drop = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit hs;
    hs = m_held && rdy_in;
    if (rx_err) begin
      m_err = sat(m_err);
      if (!m_held) begin m_rxq.delete(); m_idle = 0; end
      if (hs) m_held = 0;
    end else if (m_held) begin
      if (hs) begin
        m_held = 0;
        if (rx_v) begin m_rxq.push_back(rx_b); m_idle = 0; end
      end else if (rx_v) begin
        m_drop = sat(m_drop);
      end
    end else if (rx_v) begin
      m_rxq.push_back(rx_b);
      m_idle = 0;
      if (m_rxq.size() == N) begin
        for (int i = 0; i < N; i++) m_pkt[8*i +: 8] = m_rxq[i];
        m_held = 1;
        m_rxq.delete();
      end
    end else if (m_rxq.size() > 0) begin
      if (m_idle == T - 1) begin m_rxq.delete(); m_idle = 0; m_drop = sat(m_drop); end
      else m_idle++;
    end
    if (m_txq.size() != 0) begin
      if (tx_rdy) void'(m_txq.pop_front());
    end else if (nbf_v_in) begin
      for (int i = 0; i < N; i++) m_txq.push_back(nbf_in[8*i +: 8]);
    end
  endtask

  task automatic check_outputs();
    chk("nbf_v", 128'(nbf_v_o), 128'(m_held));
    if (m_held) chk("nbf_o", 128'(nbf_o), 128'(m_pkt));
    chk("nbf_ready", 128'(nbf_ready_and_o), 128'(m_txq.size() == 0));
    chk("tx_v", 128'(tx_v_o), 128'(m_txq.size() != 0));
    if (m_txq.size() != 0) chk("tx_o", 128'(tx_o), 128'(m_txq[0]));
    chk("drop_cnt", 128'(drop_count_o), 128'(m_drop));
    chk("err_cnt", 128'(error_count_o), 128'(m_err));
  endtask

  task automatic tick();
    if (reset) model_reset(); else model_step();
    if (tx_v_o && tx_rdy) tx_hs++;
    @(posedge clk); #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_v = 1'b1; rx_b = b; tick(); rx_v = 1'b0;
  endtask

  task automatic send_pkt(input logic [W-1:0] p, input int gap);
    for (int i = 0; i < N; i++) begin send_byte(p[8*i +: 8]); idle(gap); end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_v"}, 128'(nbf_v_o), 128'(0));
    chk({tag, "_o"}, 128'(nbf_o), 128'(0));
    chk({tag, "_rdy"}, 128'(nbf_ready_and_o), 128'(1));
    chk({tag, "_txv"}, 128'(tx_v_o), 128'(0));
    chk({tag, "_tx"}, 128'(tx_o), 128'(0));
    chk({tag, "_drop"}, 128'(drop_count_o), 128'(0));
    chk({tag, "_err"}, 128'(error_count_o), 128'(0));
  endtask

  logic [W-1:0] pw, pr, p;

  initial begin
    model_reset();
    @(posedge clk); #1;
    check_reset_vals("rst");
    idle(2);
    reset = 1'b0;
    idle(2);

    // write request, spaced bytes, downstream always ready
    pw = {64'hAB, 40'h00_8000_0000, 8'h03};
    rdy_in = 1'b1;
    send_pkt(pw, 9);
    idle(3);

    // response serialization with throttled transmitter
    pr = {64'hAB, 40'h00_8000_0000, 8'h02};
    nbf_in = pr; nbf_v_in = 1'b1; tick(); nbf_v_in = 1'b0;
    tx_hs = 0;
    for (int k = 0; k < 60; k++) begin tx_rdy = (k % 3 == 2); tick(); end
    tx_rdy = 1'b0;
    chk("tx_handshakes", 128'(tx_hs), 128'(N));

    // backpressure: hold a packet, drop three, fourth rides the handshake
    rdy_in = 1'b0;
    p = {$urandom, $urandom, $urandom, $urandom};
    send_pkt(p, 0);
    for (int i = 0; i < 3; i++) send_byte(8'(8'h50 + i));
    chk("bp_drop", 128'(drop_count_o), 128'(3));
    chk("bp_hold", 128'(nbf_o), 128'(p));
    rdy_in = 1'b1;
    send_byte(8'h77);
    p = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 1; i < N; i++) send_byte(p[8*i +: 8]);
    chk("bp_next_b0", 128'(nbf_o[7:0]), 128'(8'h77));
    idle(2);

    // error abandons partial packet, then timeout does the same
    p = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 5; i++) send_byte(p[8*i +: 8]);
    rx_err = 1'b1; tick(); rx_err = 1'b0;
    chk("err_one", 128'(error_count_o), 128'(1));
    send_pkt(p, 1);
    idle(2);
    for (int i = 0; i < 5; i++) send_byte(p[8*i +: 8]);
    idle(T + 2);
    chk("timeout_drop", 128'(drop_count_o), 128'(4));
    send_pkt(~p, 0);
    idle(2);

    // random traffic on both paths
    for (int k = 0; k < 3000; k++) begin
      rx_v   = ($urandom_range(0, 2) == 0);
      rx_b   = 8'($urandom);
      rx_err = ($urandom_range(0, 60) == 0);
      rdy_in = ($urandom_range(0, 3) != 0);
      nbf_v_in = ($urandom_range(0, 4) == 0);
      nbf_in = {$urandom, $urandom, $urandom, $urandom};
      tx_rdy = ($urandom_range(0, 1) == 0);
      tick();
    end
    rx_v = 1'b0; rx_err = 1'b0; nbf_v_in = 1'b0; tx_rdy = 1'b1; rdy_in = 1'b1;
    idle(40);
    tx_rdy = 1'b0;

    // drop counter saturation
    rdy_in = 1'b0;
    send_pkt(p, 0);
    for (int i = 0; i < 300; i++) send_byte(8'(i));
    chk("drop_sat", 128'(drop_count_o), 128'(CMAX));
    rdy_in = 1'b1; tick();

    // async reset in the middle of RX and TX activity
    nbf_in = pr; nbf_v_in = 1'b1; tick(); nbf_v_in = 1'b0;
    tx_rdy = 1'b1; tick(); tx_rdy = 1'b0;
    for (int i = 0; i < 7; i++) send_byte(p[8*i +: 8]);
    #3 reset = 1'b1;
    #1 check_reset_vals("midrst");
    model_reset();
    tick();
    reset = 1'b0;
    idle(30);
    chk("post_rst_v", 128'(nbf_v_o), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
